acorn_decrypt_process: RTL and testbench
========================================

ACORN_DECRYPT_PROCESS -- requirements
Module: acorn_decrypt_process

Interface
REQ-001 Parameter MSG_LEN_W, default 16, width of the message-length input in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a decryption; sampled only in IDLE.
REQ-005 msg_len  input  MSG_LEN_W  ciphertext length in bits, sampled with start.
REQ-006 state_in  input  293  cipher state after associated-data processing, sampled with start.
REQ-007 c_bit / c_valid  input  1 / 1  serial ciphertext bit and its valid qualifier.
REQ-008 c_ready  output  1  block accepts c_bit this cycle.
REQ-009 p_bit / p_valid  output  1 / 1  recovered plaintext bit, registered, with one-cycle valid pulse.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; state_out valid in the same cycle.
REQ-012 state_out  output  293  cipher state after message and padding absorption, held until the next start.

Function
REQ-013 The FSM SHALL have states IDLE, DATA, PAD and DONE.
REQ-014 In IDLE, start=1 SHALL load S<=state_in, clear the bit counter, and go to DATA, or to PAD if msg_len==0.
REQ-015 Each step SHALL apply the ACORN-128 bit step to S: six LFSR feedback updates; ks=S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66); f=S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks); shift S down by one; S292<=f^m.
REQ-016 DATA: c_ready=1; a step SHALL occur only on c_valid&c_ready, with p=c_bit^ks, m=p, ca=1, cb=0.
REQ-017 On each step in DATA, p_bit<=p SHALL be registered with p_valid=1 the next cycle; p_valid SHALL be 0 otherwise.
REQ-018 DATA SHALL stall without any state change while c_valid=0.
REQ-019 After accepting bit msg_len-1, the FSM SHALL go to PAD, with the pad counter cleared.
REQ-020 PAD SHALL run 256 unconditional steps: m=1 at pad index 0 and 0 otherwise; ca=1 for indices 0..127 and 0 for 128..255; cb=0; c_ready=0.
REQ-021 After pad index 255, the FSM SHALL go to DONE; DONE SHALL assert done, drive state_out=S, and return to IDLE on the next cycle.
REQ-022 start outside IDLE SHALL be ignored; msg_len and state_in SHALL be ignored outside the start cycle.
REQ-023 Counters SHALL be MSG_LEN_W bits for data and 9 bits for padding, and SHALL never wrap within one operation.

Reset
REQ-024 rst low SHALL force IDLE immediately and clear S, both counters, state_out, p_bit, p_valid, c_ready, busy and done to 0.
REQ-025 Reset mid-operation SHALL abort it with no done pulse; operation restarts only on a new start.

Configuration
REQ-026 With ACORN_DEC_KS_OBS_EN defined, the block SHALL add an output port ks_bit (1 bit) carrying the registered keystream bit, aligned with p_valid.
REQ-027 Without ACORN_DEC_KS_OBS_EN, the ks_bit port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package acorn_pkg SHALL hold STATE_W=293, PAD_LEN=256, PAD_CA_LEN=128, the FSM state enum, and the maj/ch helper functions.
REQ-029 The one-bit state step SHALL be a combinational sub-module acorn_step (inputs S, m, ca, cb; outputs S_next, ks), shareable with the encrypt process.

Verification
REQ-030 Reset: rst=0 mid-PAD -> busy=0, done=0, state_out=0, c_ready=0 in the same cycle; no done pulse after release.
REQ-031 state_in=0, msg_len=0, start -> no c_ready, exactly 256 PAD steps, done pulse 258 cycles after start; state_out equals the reference-model value.
REQ-032 state_in=0, msg_len=1, c_bit=1 -> ks=0, so p_bit=1 with p_valid one cycle after acceptance.
REQ-033 Round trip: encrypt 64 random bits with a golden model from a random state, then decrypt -> plaintext recovered bit-exact, and state_out equals the encrypt-side final state.
REQ-034 Backpressure: c_valid low for 10 cycles mid-message -> S, counter and p_valid unchanged; results identical to the unstalled run.
REQ-035 start pulsed while busy, with a different state_in -> ignored; output matches the first operation only.

Source files
------------

// File: rtl/acorn_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | acorn_pkg                                                             |
// | Shared ACORN-128 constants, FSM state type and boolean helpers.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package acorn_pkg;

  localparam int STATE_W    = 293;
  localparam int PAD_LEN    = 256;
  localparam int PAD_CA_LEN = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acorn_decrypt_process_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | acorn_decrypt_process_if                                              |
// | Control, serial ciphertext/plaintext and state bus of the decryptor.  |
// | Optional ks_bit observation port: ACORN_DEC_KS_OBS_EN.                |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface acorn_decrypt_process_if #(
  parameter int MSG_LEN_W = 16
);
  import acorn_pkg::*;

  logic                 start;
  logic [MSG_LEN_W-1:0] msg_len;
  logic [STATE_W-1:0]   state_in;
  logic                 c_bit;
  logic                 c_valid;
  logic                 c_ready;
  logic                 p_bit;
  logic                 p_valid;
  logic                 busy;
  logic                 done;
  logic [STATE_W-1:0]   state_out;
`ifdef ACORN_DEC_KS_OBS_EN
  logic                 ks_bit;
`endif

  modport master (
    output start, msg_len, state_in, c_bit, c_valid,
    input  c_ready, p_bit, p_valid, busy, done, state_out
`ifdef ACORN_DEC_KS_OBS_EN
    , input ks_bit
`endif
  );

  modport slave (
    input  start, msg_len, state_in, c_bit, c_valid,
    output c_ready, p_bit, p_valid, busy, done, state_out
`ifdef ACORN_DEC_KS_OBS_EN
    , output ks_bit
`endif
  );

endinterface
`default_nettype wire

// File: rtl/acorn_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | acorn_step                                                            |
// | Combinational ACORN-128 one-bit state update and keystream bit.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module acorn_step
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] S,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic [STATE_W-1:0] S_next,
  output logic               ks
);

  logic [STATE_W-1:0] w_s;
  logic               w_f;

  // ks is kept free of m so a caller may derive m from ks without a loop
  always_comb begin
    w_s      = S;
    w_s[289] = S[289] ^ S[235] ^ S[230];
    w_s[230] = S[230] ^ S[196] ^ S[193];
    w_s[193] = S[193] ^ S[160] ^ S[154];
    w_s[154] = S[154] ^ S[111] ^ S[107];
    w_s[107] = S[107] ^ S[66]  ^ S[61];
    w_s[61]  = S[61]  ^ S[23]  ^ S[0];
    ks = w_s[12] ^ w_s[154] ^ maj(w_s[235], w_s[61], w_s[193])
       ^ ch(w_s[230], w_s[111], w_s[66]);
  end

  assign w_f = w_s[0] ^ ~w_s[107] ^ maj(w_s[244], w_s[23], w_s[160])
             ^ (ca & w_s[196]) ^ (cb & ks);

  assign S_next = {w_f ^ m, w_s[STATE_W-1:1]};

endmodule
`default_nettype wire

// File: rtl/acorn_decrypt_process.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | acorn_decrypt_process                                                 |
// | ACORN-128 serial decryption followed by 256-step padding absorption.  |
// | Optional ks_bit observation port: ACORN_DEC_KS_OBS_EN.                |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module acorn_decrypt_process
  import acorn_pkg::*;
#(
  parameter int MSG_LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  acorn_decrypt_process_if.slave  bus
);

  fsm_t                 r_fsm, w_fsm_nxt;
  logic [STATE_W-1:0]   r_s;
  logic [MSG_LEN_W-1:0] r_len;
  logic [MSG_LEN_W-1:0] r_data_cnt;
  logic [8:0]           r_pad_cnt;
  logic [STATE_W-1:0]   r_state_out;
  logic                 r_p_bit;
  logic                 r_p_valid;

  logic                 w_c_ready;
  logic                 w_step_en;
  logic                 w_step_m;
  logic                 w_step_ca;
  logic                 w_step_cb;
  logic [STATE_W-1:0]   w_s_next;
  logic                 w_ks;
  logic                 w_p;

  acorn_step u_step (
    .S      (r_s),
    .m      (w_step_m),
    .ca     (w_step_ca),
    .cb     (w_step_cb),
    .S_next (w_s_next),
    .ks     (w_ks)
  );

  assign w_p = bus.c_bit ^ w_ks;

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_c_ready = 1'b0;
    w_step_en = 1'b0;
    w_step_m  = 1'b0;
    w_step_ca = 1'b1;
    w_step_cb = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (bus.start)
          w_fsm_nxt = (bus.msg_len == '0) ? PAD : DATA;
      end
      DATA: begin
        w_c_ready = 1'b1;
        w_step_m  = w_p;
        if (bus.c_valid) begin
          w_step_en = 1'b1;
          if (r_data_cnt == (r_len - MSG_LEN_W'(1)))
            w_fsm_nxt = PAD;
        end
      end
      PAD: begin
        w_step_en = 1'b1;
        w_step_m  = (r_pad_cnt == 9'd0);
        w_step_ca = (r_pad_cnt < 9'(PAD_CA_LEN));
        if (r_pad_cnt == 9'(PAD_LEN - 1))
          w_fsm_nxt = DONE;
      end
      DONE: begin
        w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm       <= IDLE;
      r_s         <= '0;
      r_len       <= '0;
      r_data_cnt  <= '0;
      r_pad_cnt   <= '0;
      r_state_out <= '0;
      r_p_bit     <= 1'b0;
      r_p_valid   <= 1'b0;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_p_valid <= 1'b0;
      if (r_fsm == IDLE && bus.start) begin
        r_s        <= bus.state_in;
        r_len      <= bus.msg_len;
        r_data_cnt <= '0;
        r_pad_cnt  <= '0;
      end
      if (w_step_en)
        r_s <= w_s_next;
      if (r_fsm == DATA && w_step_en) begin
        r_data_cnt <= r_data_cnt + MSG_LEN_W'(1);
        r_p_bit    <= w_p;
        r_p_valid  <= 1'b1;
      end
      if (r_fsm == DATA && w_fsm_nxt == PAD)
        r_pad_cnt <= '0;
      if (r_fsm == PAD)
        r_pad_cnt <= r_pad_cnt + 9'd1;
      // Captured on the last pad step so it is already valid during DONE
      if (r_fsm == PAD && w_fsm_nxt == DONE)
        r_state_out <= w_s_next;
    end
  end

`ifdef ACORN_DEC_KS_OBS_EN
  logic r_ks_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ks_bit <= 1'b0;
    else if (r_fsm == DATA && w_step_en)
      r_ks_bit <= w_ks;
  end

  assign bus.ks_bit = r_ks_bit;
`endif

  assign bus.c_ready   = w_c_ready;
  assign bus.p_bit     = r_p_bit;
  assign bus.p_valid   = r_p_valid;
  assign bus.busy      = (r_fsm != IDLE);
  assign bus.done      = (r_fsm == DONE);
  assign bus.state_out = r_state_out;

endmodule
`default_nettype wire

// File: tb/tb_acorn_decrypt_process.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_acorn_decrypt_process                                              |
// | Scoreboard bench: golden ACORN model feeds queues, a monitor checks.  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_acorn_decrypt_process;
  import acorn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [1:0]         exp_p[$];   // {plaintext bit, keystream bit}
  logic [STATE_W-1:0] exp_s[$];

  acorn_decrypt_process_if #(.MSG_LEN_W(16)) bus ();

  acorn_decrypt_process #(.MSG_LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- golden model ----------------
  function automatic logic f_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic f_ch(input logic x, input logic y, input logic z);
    return x ? y : z;
  endfunction

  function automatic logic [STATE_W-1:0] lfsr_of(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    return t;
  endfunction

  function automatic logic ks_of(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t = lfsr_of(s);
    return t[12] ^ t[154] ^ f_maj(t[235], t[61], t[193]) ^ f_ch(t[230], t[111], t[66]);
  endfunction

  function automatic logic [STATE_W-1:0] next_of(input logic [STATE_W-1:0] s, input logic m,
                                                 input logic ca, input logic cb);
    logic [STATE_W-1:0] t = lfsr_of(s);
    logic               f;
    f = t[0] ^ !t[107] ^ f_maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks_of(s));
    return (t >> 1) | ({{(STATE_W-1){1'b0}}, f ^ m} << (STATE_W-1));
  endfunction

  function automatic logic [STATE_W-1:0] pad_of(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r = s;
    for (int i = 0; i < 256; i++)
      r = next_of(r, i == 0, i < 128, 1'b0);
    return r;
  endfunction

  // Encrypt p with the model, produce ciphertext and queue what decryption must yield
  task automatic enc_push(input logic [STATE_W-1:0] st, input int n, input logic [63:0] p,
                          output logic [63:0] c);
    logic [STATE_W-1:0] s = st;
    logic               k;
    c = '0;
    for (int i = 0; i < n; i++) begin
      k    = ks_of(s);
      c[i] = p[i] ^ k;
      exp_p.push_back({p[i], k});
      s    = next_of(s, p[i], 1'b1, 1'b0);
    end
    exp_s.push_back(pad_of(s));
  endtask

  function automatic logic [STATE_W-1:0] rand_state();
    logic [STATE_W-1:0] r;
    for (int i = 0; i < STATE_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.p_valid) begin
          if (exp_p.size() == 0) begin
            chk("unexpected_p_valid", 1, 0);
          end else begin
            e = exp_p.pop_front();
            chk("p_bit", bus.p_bit, e[1]);
`ifdef ACORN_DEC_KS_OBS_EN
            chk("ks_bit", bus.ks_bit, e[0]);
`endif
          end
        end
        if (bus.done) begin
          if (exp_s.size() == 0) chk("unexpected_done", 1, 0);
          else chk("state_out", bus.state_out, exp_s.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_s.size() != 0 || exp_p.size() != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic run_dec(input string name, input logic [STATE_W-1:0] st, input int n,
                         input logic [63:0] c, input int stall_at, input int busy_start_at);
    int k;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.state_in = st; bus.msg_len = 16'(n);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.state_in = ~st; bus.msg_len = 16'd7;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.c_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          chk({name, "_stall_c_ready"}, bus.c_ready, 1);
          if (j > 0) chk({name, "_stall_p_valid"}, bus.p_valid, 0);
          @(posedge clk); #1;
        end
      end
      bus.c_bit = c[i]; bus.c_valid = 1'b1;
      if (i == busy_start_at) bus.start = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.c_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) chk({name, "_c_ready_timeout"}, 1, 0);
      @(posedge clk); #1;
      bus.c_valid = 1'b0; bus.start = 1'b0;
    end
    if (busy_start_at >= 0) begin
      repeat (5) @(posedge clk);
      #1 bus.start = 1'b1; bus.msg_len = 16'd0;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    wait_drain(name);
  endtask

  initial begin
    logic [STATE_W-1:0] st;
    logic [63:0]        p, c;
    int                 dc, seen, cr, ndone;

    bus.start = 1'b0; bus.msg_len = '0; bus.state_in = '0;
    bus.c_bit = 1'b0; bus.c_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_c_ready", bus.c_ready, 0);
    chk("rst_p_valid", bus.p_valid, 0);
    chk("rst_state_out", bus.state_out, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Empty message: done shows in the 258th cycle counting the start cycle,
    // i.e. on the 257th falling edge after the edge that samples start
    exp_s.push_back(pad_of('0));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.state_in = '0; bus.msg_len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dc = 0; seen = 0; cr = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.c_ready) cr = 1;
      if (bus.done && seen == 0) begin seen = 1; dc = k; end
    end
    chk("empty_done_cycle", 32'(dc), 257);
    chk("empty_c_ready_seen", 32'(cr), 0);
    wait_drain("empty");

    // One bit from the zero state: ks=0, so c_bit=1 decrypts to 1
    exp_p.push_back(2'b10);
    exp_s.push_back(pad_of(next_of('0, 1'b1, 1'b1, 1'b0)));
    run_dec("onebit", '0, 1, 64'd1, -1, -1);

    // Round trip of 64 random bits, then the same traffic with a 10-cycle stall
    st = rand_state();
    p  = {$urandom, $urandom};
    enc_push(st, 64, p, c);
    run_dec("roundtrip", st, 64, c, -1, -1);
    enc_push(st, 64, p, c);
    run_dec("stall", st, 64, c, 30, -1);

    // start pulsed during DATA and PAD with a different state_in is ignored
    st = rand_state();
    p  = {$urandom, $urandom};
    enc_push(st, 20, p, c);
    run_dec("busy_start", st, 20, c, -1, 7);

    // Abort mid-PAD: outputs clear combinationally, no done afterwards
    @(posedge clk); #1;
    bus.start = 1'b1; bus.state_in = rand_state(); bus.msg_len = '0;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_state_out", bus.state_out, 0);
    chk("abort_c_ready", bus.c_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);
    chk("abort_idle", bus.busy, 0);

    chk("leftover_p", 32'(exp_p.size()), 0);
    chk("leftover_s", 32'(exp_s.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
